spi_fifo_v2: RTL and testbench

- Parametrised successor to the SPI byte buffer: synchronous single-clock FIFO between the SPI shift engine and the host side.
- Adds async reset, full-depth usage via extra pointer bit, occupancy count, programmable almost-full/almost-empty, selectable show-ahead (FWFT) or registered read, and sticky overflow/underflow error flags.
- One instance per direction (TX and RX) in the SPI controller.

---
 rtl/spi_fifo_v2.sv | 144 ++++++++++++++
 tb/tb_spi_fifo_v2.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_fifo_v2.sv
// Single-clock FIFO between the SPI shift engine and the host side, one per direction.
// Occupancy is a dedicated register; status flags decode from it, error flags are sticky.
module spi_fifo_v2 #(
    parameter int DEPTH    = 128,
    parameter int DWIDTH   = 8,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       flush,
    input  logic                       buff_WEn,
    input  logic [DWIDTH-1:0]          dataIn,
    input  logic                       buff_REn,
    output logic [DWIDTH-1:0]          dataOut,
    output logic                       o_valid,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

    // Handshake: buff_WEn/buff_REn are requests that take effect only when the
    // FIFO is not full/not empty at the start of the cycle; o_valid qualifies dataOut.

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          wr_acc;
    logic          rd_acc;
    logic [AW-1:0] widx;
    logic [AW-1:0] ridx;

    assign widx = wptr_q[AW-1:0];
    assign ridx = rptr_q[AW-1:0];

    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    always_comb begin
        wr_acc  = buff_WEn && !full && !flush;
        rd_acc  = buff_REn && !empty && !flush;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + PW'(1);
            if (rd_acc) rptr_d = rptr_q + PW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + PW'(1);
                2'b01:   count_d = count_q - PW'(1);
                default: count_d = count_q;
            endcase
            // Rejected requests are recorded but never stall the other side.
            if (buff_WEn && full)  ovf_d = 1'b1;
            if (buff_REn && empty) udf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage has no reset; a word becomes readable the cycle after it is written.
    always_ff @(posedge i_clk) begin
        if (wr_acc) mem[widx] <= dataIn;
    end

    if (FWFT != 0) begin : g_fwft
        assign dataOut = mem[ridx];
        assign o_valid = !empty;
    end else begin : g_reg
        logic [DWIDTH-1:0] dout_q, dout_d;
        logic              valid_q, valid_d;

        always_comb begin
            dout_d  = dout_q;
            valid_d = 1'b0;
            if (rd_acc) begin
                dout_d  = mem[ridx];
                valid_d = 1'b1;
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                dout_q  <= dout_d;
                valid_q <= valid_d;
            end
        end

        assign dataOut = dout_q;
        assign o_valid = valid_q;
    end

    // The occupancy register must always agree with the pointer distance.
    a_count_matches_ptrs: assert property (@(posedge i_clk) disable iff (i_rst)
        count_q == PW'(wptr_q - rptr_q));
    a_count_in_range: assert property (@(posedge i_clk) disable iff (i_rst)
        count_q <= DEPTH_C);

endmodule

// File: tb/tb_spi_fifo_v2.sv
// Bench for spi_fifo_v2: a registered-read and a show-ahead instance share one stimulus
// stream and are checked against a queue-based reference model of an 8-entry FIFO.
module tb_spi_fifo_v2;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           buff_WEn;
    logic [7:0]     dataIn;
    logic           buff_REn;

    logic [7:0]     dout0, dout1;
    logic           valid0, valid1;
    logic           empty0, empty1, full0, full1;
    logic           af0, af1, ae0, ae1;
    logic [CW-1:0]  count0, count1;
    logic           ovf0, ovf1, udf0, udf1;

    spi_fifo_v2 #(.DEPTH(DEPTH), .DWIDTH(8), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)) u_reg (
        .i_clk(clk), .i_rst(rst), .flush(flush),
        .buff_WEn(buff_WEn), .dataIn(dataIn), .buff_REn(buff_REn),
        .dataOut(dout0), .o_valid(valid0), .empty(empty0), .full(full0),
        .almost_full(af0), .almost_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(udf0)
    );

    spi_fifo_v2 #(.DEPTH(DEPTH), .DWIDTH(8), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(2)) u_fwft (
        .i_clk(clk), .i_rst(rst), .flush(flush),
        .buff_WEn(buff_WEn), .dataIn(dataIn), .buff_REn(buff_REn),
        .dataOut(dout1), .o_valid(valid1), .empty(empty1), .full(full1),
        .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(udf1)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model / scoreboard state ----------------
    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    bit         m_ovf;
    bit         m_udf;
    logic [7:0] m_last;
    int         n_vec;
    int         n_miss;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear(input bit hard);
        model_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        if (hard) begin
            m_last = 8'h00;
            exp_q.delete();
        end
    endtask

    task automatic check_status();
        int n;
        n = model_q.size();
        chk("count0", 32'(count0), 32'(n));
        chk("count1", 32'(count1), 32'(n));
        chk("empty", 32'({empty0, empty1}), 32'({2{n == 0}}));
        chk("full", 32'({full0, full1}), 32'({2{n == DEPTH}}));
        chk("almost_full", 32'({af0, af1}), 32'({2{n >= 6}}));
        chk("almost_empty", 32'({ae0, ae1}), 32'({2{n <= 2}}));
        chk("overflow", 32'({ovf0, ovf1}), 32'({2{m_ovf}}));
        chk("underflow", 32'({udf0, udf1}), 32'({2{m_udf}}));
        chk("reg_dataOut_hold", 32'(dout0), 32'(m_last));
        chk("fwft_valid", 32'(valid1), 32'(n != 0));
        if (n != 0) chk("fwft_dataOut", 32'(dout1), 32'(model_q[0]));
    endtask

    // One clock of stimulus; the model advances from the state seen at the start of the cycle.
    task automatic step(input bit we, input logic [7:0] din, input bit re, input bit fl);
        bit full_s, empty_s, wa, ra;
        buff_WEn = we;
        dataIn   = din;
        buff_REn = re;
        flush    = fl;
        full_s   = (model_q.size() == DEPTH);
        empty_s  = (model_q.size() == 0);
        wa = we && !full_s && !fl;
        ra = re && !empty_s && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            model_clear(1'b0);
        end else begin
            if (we && full_s)  m_ovf = 1'b1;
            if (re && empty_s) m_udf = 1'b1;
            if (ra) begin
                m_last = model_q.pop_front();
                exp_q.push_back(m_last);
            end
            if (wa) model_q.push_back(din);
        end
        buff_WEn = 1'b0;
        buff_REn = 1'b0;
        flush    = 1'b0;
        check_status();
    endtask

    // ---------------- monitor: registered-read output stream ----------------
    always @(negedge clk) begin
        if (!rst && valid0) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL reg_valid_unexpected: got valid with data %0h expected no output", dout0);
            end else begin
                chk("reg_read_data", 32'(dout0), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 500000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int wprob, rprob;
        n_vec = 0;
        n_miss = 0;
        rst = 1'b1;
        flush = 1'b0;
        buff_WEn = 1'b0;
        buff_REn = 1'b0;
        dataIn = 8'h00;
        model_clear(1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_status();
        chk("reset_valid0", 32'(valid0), 32'd0);
        rst = 1'b0;

        // Fill, overflow attempt, drain, underflow attempt.
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("flags_sticky", 32'({ovf0, udf0}), 32'b11);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous read/write at count 3 across a pointer wrap.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
        chk("rw_count_steady", 32'(count0), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous read/write while full, then while empty.
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("rw_full_count", 32'(count0), 32'd7);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk("rw_empty_count", 32'(count0), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Show-ahead: word visible without a pop, next word visible as the pop lands.
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("fwft_first_word", 32'({valid1, dout1}), 32'h15A);
        step(1'b1, 8'h6B, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fwft_after_pop", 32'({count1, dout1}), {24'd0, 4'd1, 8'h6B});
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Randomised traffic with alternating fill/drain bias and rare flushes.
        for (int ph = 0; ph < 6; ph++) begin
            wprob = (ph % 2 == 0) ? 80 : 25;
            rprob = (ph % 2 == 0) ? 25 : 80;
            for (int i = 0; i < 60; i++) begin
                step($urandom_range(0, 99) < wprob, 8'($urandom_range(0, 255)),
                     $urandom_range(0, 99) < rprob, $urandom_range(0, 99) < 2);
            end
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset between edges with five words stored.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count", 32'(count0), 32'd0);
        chk("async_rst_empty", 32'({empty0, empty1}), 32'b11);
        chk("async_rst_dataOut", 32'(dout0), 32'd0);
        model_clear(1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_status();

        // Flush together with a write drops the write.
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b1, 8'h44, 1'b0, 1'b1);
        chk("flush_drops_write", 32'(count0), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        chk("all_reads_delivered", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
